// File: rtl/round_timer.sv
// Round countdown timer: loads on start_round, counts whole seconds down while
// game_on is high, and raises time_up when the round reaches 00.
module round_timer #(
   parameter int CLK_HZ        = 65000000,
   parameter int ROUND_SECONDS = 60,
   parameter int WARN_SECONDS  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_round,
   input  logic       game_on,
   input  logic       abort,
   output logic       time_up,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic       warn,
   output logic       sec_tick
);

   localparam int             PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
   localparam logic [3:0]    INIT_TENS = 4'(ROUND_SECONDS / 10);
   localparam logic [3:0]    INIT_ONES = 4'(ROUND_SECONDS % 10);
   localparam logic [6:0]    WARN_LIM  = 7'(WARN_SECONDS);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      EXPIRED
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] pre, pre_n;
   logic [3:0]    tens_n, ones_n;
   logic          tick_n, time_up_n, warn_n;
   logic [6:0]    remain_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         pre       <= '0;
         secs_tens <= INIT_TENS;
         secs_ones <= INIT_ONES;
         time_up   <= 1'b0;
         warn      <= 1'b0;
         sec_tick  <= 1'b0;
      end else begin
         state     <= state_n;
         pre       <= pre_n;
         secs_tens <= tens_n;
         secs_ones <= ones_n;
         time_up   <= time_up_n;
         warn      <= warn_n;
         sec_tick  <= tick_n;
      end
   end

   // start_round outranks abort, which outranks the per-second tick
   always_comb begin
      state_n = state;
      pre_n   = pre;
      tens_n  = secs_tens;
      ones_n  = secs_ones;
      tick_n  = 1'b0;
      if (start_round) begin
         state_n = RUN;
         pre_n   = '0;
         tens_n  = INIT_TENS;
         ones_n  = INIT_ONES;
      end else if (abort) begin
         state_n = IDLE;
         pre_n   = '0;
         tens_n  = INIT_TENS;
         ones_n  = INIT_ONES;
      end else begin
         case (state)
            IDLE: pre_n = '0;
            RUN: begin
               if (game_on) begin
                  if (pre == PRE_MAX) begin
                     pre_n  = '0;
                     tick_n = 1'b1;
                     // reaching 00 ends the round at the same edge, so no underflow
                     if (secs_tens == 4'd0 && secs_ones == 4'd1) begin
                        tens_n  = 4'd0;
                        ones_n  = 4'd0;
                        state_n = EXPIRED;
                     end else if (secs_ones == 4'd0) begin
                        ones_n = 4'd9;
                        tens_n = secs_tens - 4'd1;
                     end else begin
                        ones_n = secs_ones - 4'd1;
                     end
                  end else begin
                     pre_n = pre + PW'(1);
                  end
               end
            end
            EXPIRED: begin
               pre_n  = '0;
               tens_n = 4'd0;
               ones_n = 4'd0;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      remain_n  = ({3'b000, tens_n} * 7'd10) + {3'b000, ones_n};
      time_up_n = (state_n == EXPIRED);
      warn_n    = (state_n == RUN) && (remain_n != 7'd0) && (remain_n <= WARN_LIM);
   end

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer: expectations are queued as stimulus is
// driven and popped/compared one cycle later against a 12 s and a 1 s timer.
module tb_round_timer;

   logic       clk = 1'b0;
   logic       rst, start_round, game_on, abort;
   logic       a_time_up, a_warn, a_sec_tick;
   logic [3:0] a_tens, a_ones;
   logic       b_time_up, b_warn, b_sec_tick;
   logic [3:0] b_tens, b_ones;

   typedef struct {
      string       tag;
      int          unit_sel;
      logic [10:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   round_timer #(.CLK_HZ(4), .ROUND_SECONDS(12), .WARN_SECONDS(3)) dut_a (
      .clk(clk), .rst(rst), .start_round(start_round), .game_on(game_on), .abort(abort),
      .time_up(a_time_up), .secs_tens(a_tens), .secs_ones(a_ones), .warn(a_warn),
      .sec_tick(a_sec_tick)
   );

   round_timer #(.CLK_HZ(4), .ROUND_SECONDS(1), .WARN_SECONDS(0)) dut_b (
      .clk(clk), .rst(rst), .start_round(start_round), .game_on(game_on), .abort(abort),
      .time_up(b_time_up), .secs_tens(b_tens), .secs_ones(b_ones), .warn(b_warn),
      .sec_tick(b_sec_tick)
   );

   function automatic logic [10:0] packExp(input int secs, input bit tu, input bit w, input bit st);
      logic [3:0] t, o;
      t = 4'(secs / 10);
      o = 4'(secs % 10);
      return {t, o, tu, w, st};
   endfunction

   task automatic applyStimulus(input logic r, input logic s, input logic g, input logic a);
      rst         = r;
      start_round = s;
      game_on     = g;
      abort       = a;
   endtask

   task automatic expectOut(input string tag, input int unit_sel, input int secs,
                            input bit tu, input bit w, input bit st);
      exp_t e;
      e.tag      = tag;
      e.unit_sel = unit_sel;
      e.val      = packExp(secs, tu, w, st);
      sb.push_back(e);
   endtask

   // Expected 12 s timer outputs k enabled cycles after the start edge
   task automatic pushRound(input string tag, input int k);
      int secs;
      secs = 12 - k / 4;
      expectOut($sformatf("%s_k%0d", tag, k), 0, secs, secs == 0,
                (secs >= 1) && (secs <= 3), (k % 4) == 0);
   endtask

   task automatic checkOutput;
      exp_t        e;
      logic [10:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.unit_sel == 0)
            obs = {a_tens, a_ones, a_time_up, a_warn, a_sec_tick};
         else
            obs = {b_tens, b_ones, b_time_up, b_warn, b_sec_tick};
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("[TB] FAIL %s observed={tens,ones,tu,warn,tick}=%h expected=%h",
                   e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cycle;
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic runFor(input string tag, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         pushRound(tag, k);
         cycle();
      end
   endtask

   initial begin
      $display("[TB] round_timer bench start");

      // Reset for two cycles, then idle with no inputs
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         expectOut($sformatf("reset_%0d", i), 0, 12, 1'b0, 1'b0, 1'b0);
         expectOut($sformatf("reset1s_%0d", i), 1, 1, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         expectOut($sformatf("idle_hold_%0d", i), 0, 12, 1'b0, 1'b0, 1'b0);
         cycle();
      end

      // Full round, with the 1 s timer expiring after a single tick
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      expectOut("start", 0, 12, 1'b0, 1'b0, 1'b0);
      expectOut("start1s", 1, 1, 1'b0, 1'b0, 1'b0);
      cycle();
      runFor("round", 1, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      pushRound("round", 3);
      expectOut("one_sec_k3", 1, 1, 1'b0, 1'b0, 1'b0);
      cycle();
      pushRound("round", 4);
      expectOut("one_sec_k4", 1, 0, 1'b1, 1'b0, 1'b1);
      cycle();
      pushRound("round", 5);
      expectOut("one_sec_k5", 1, 0, 1'b1, 1'b0, 1'b0);
      cycle();
      runFor("round", 6, 48);

      // EXPIRED holds regardless of game_on
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, logic'(i % 2), 1'b0);
         expectOut($sformatf("expired_%0d", i), 0, 0, 1'b1, 1'b0, 1'b0);
         cycle();
      end

      // Restart, run to 07 plus two prescaler counts, then pause
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      expectOut("restart", 0, 12, 1'b0, 1'b0, 1'b0);
      cycle();
      runFor("r2", 1, 22);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
         expectOut($sformatf("pause_%0d", i), 0, 7, 1'b0, 1'b0, 1'b0);
         cycle();
      end
      runFor("resume", 23, 28);

      // Abort at 05 returns to IDLE with 12
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      expectOut("abort", 0, 12, 1'b0, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         expectOut($sformatf("abort_idle_%0d", i), 0, 12, 1'b0, 1'b0, 1'b0);
         cycle();
      end

      // start_round beats abort
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      expectOut("start_abort", 0, 12, 1'b0, 1'b0, 1'b0);
      cycle();
      runFor("prio", 1, 6);

      // rst mid-round returns to IDLE
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      expectOut("mid_reset", 0, 12, 1'b0, 1'b0, 1'b0);
      cycle();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         expectOut($sformatf("post_reset_%0d", i), 0, 12, 1'b0, 1'b0, 1'b0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
- Round countdown timer for the race. Sits directly upstream of the game state controller and produces the level `time_up` that ends a round.
- Loads on the controller's one-cycle start-of-round indication and counts down whole seconds while the game is on.
- Exposes BCD digits, a low-time warning and a per-second pulse for the HUD and sound blocks.

Parameters:
- CLK_HZ, 65000000, system clock frequency; the prescaler divides by this to get 1 s.
- ROUND_SECONDS, 60, round length in seconds; legal range 1..99.
- WARN_SECONDS, 10, warning threshold in seconds; legal range 0..ROUND_SECONDS.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start_round  in  1  one-cycle (or longer) request to load and start a round; a level is tolerated
- game_on  in  1  high while the race is in progress; counting is enabled only when high
- abort  in  1  return to idle (title screen shown)
- time_up  out  1  high while in EXPIRED
- secs_tens  out  4  BCD tens digit of remaining seconds
- secs_ones  out  4  BCD ones digit of remaining seconds
- warn  out  1  low-time warning
- sec_tick  out  1  one-cycle pulse on each decrement

Behaviour:
- All outputs are registered.
- States: IDLE, RUN, EXPIRED.
- Reset (rst=1 at a clk edge):
  - state=IDLE, prescaler=0.
  - Digits = BCD of ROUND_SECONDS (60 -> tens=6, ones=0).
  - time_up=0, warn=0, sec_tick=0.
  - rst wins over every other input.
- Input priority per cycle: rst > start_round > abort > tick.
- start_round=1, in any state:
  - Digits reload to ROUND_SECONDS, prescaler cleared, state goes to RUN.
  - sec_tick=0 that cycle.
  - If held high, the block keeps reloading and no count occurs.
- abort=1 (start_round=0), in any state:
  - State goes to IDLE and digits reload to ROUND_SECONDS; prescaler cleared.
- IDLE: holds; prescaler stays at 0.
- Prescaler:
  - Counts 0..CLK_HZ-1, only in RUN with game_on=1.
  - tick is asserted in the cycle the prescaler equals CLK_HZ-1; the prescaler then wraps to 0.
  - With game_on=0 in RUN, the prescaler and digits freeze (pause). They resume from the frozen value when game_on returns.
- On a tick in RUN:
  - BCD decrement: if ones=0 then ones=9 and tens=tens-1, else ones=ones-1.
  - sec_tick=1 on the following cycle, aligned with the new digit values.
  - If the pre-decrement value is 01, digits become 00 and the state goes to EXPIRED at that same edge.
- Latency: the first decrement occurs CLK_HZ enabled cycles after leaving the start_round cycle.
- EXPIRED:
  - Digits hold 00, time_up=1, prescaler held 0, sec_tick=0.
  - Stays until start_round or abort; game_on has no effect.
- warn = 1 iff state is RUN and the remaining value is >0 and <=WARN_SECONDS. warn=0 in IDLE and EXPIRED.
- Digits are never outside 0..9.
- Underflow below 00 is impossible because EXPIRED is entered at 01->00.
- ROUND_SECONDS=1: the first tick goes straight to EXPIRED.
- The prescaler needs ceil(log2(CLK_HZ)) bits.

Test Plan:
- Bench parameters for all scenarios: CLK_HZ=4, ROUND_SECONDS=12, WARN_SECONDS=3.
- Reset: rst=1 for 2 cycles, then release -> tens=1, ones=2, time_up=0, warn=0, sec_tick=0, and the digits hold with no inputs applied.
- Full round: start_round pulse, then game_on=1 -> sec_tick every 4 cycles; digits go 12,11,10,09 (ones wraps 0->9, tens 1->0) … 01,00. warn rises when digits reach 03 and falls at 00. time_up=1 exactly when digits read 00, 48 cycles after start. EXPIRED holds 00 for 20 further cycles.
- Pause: in RUN at 07, drop game_on for 10 cycles -> digits stay 07 and sec_tick stays 0. Raise game_on -> the next decrement lands after the remaining prescaler count, not a fresh 4.
- Restart from EXPIRED: start_round pulse -> time_up=0 next cycle, digits 12, countdown repeats.
- Abort and priority:
  - abort mid-round at 05 -> IDLE, digits 12, warn=0.
  - start_round and abort together -> RUN with 12.
  - rst asserted mid-round -> IDLE, 12.
- Edge: ROUND_SECONDS=1 -> a single tick gives 00 and time_up=1, 4 cycles after start.
